// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Groups the display-value handshake and the display drive lines of the
//   four-digit seven-segment scanner.
//
//   data_in    [15:0]  four hex nibbles, [3:0] = digit 0 (rightmost)
//   load               single-cycle strobe, captures data_in into the pending buffer
//   blank_mask [3:0]   bit k = 1 keeps digit k dark (live, not buffered)
//   busy               high while a pending value awaits commit
//   anode      [3:0]   active-low digit enables, bit k = digit k
//   segment    [6:0]   active-low segments, order {g,f,e,d,c,b,a}
//
//   master: the side supplying display values (drives data_in/load/blank_mask)
//   slave : the scanner itself
interface seven_seg_scanner_if;
  logic [15:0] data_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic        busy;
  logic [3:0]  anode;
  logic [6:0]  segment;

  modport master (
    output data_in, load, blank_mask,
    input  busy, anode, segment
  );

  modport slave (
    input  data_in, load, blank_mask,
    output busy, anode, segment
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a four-digit common-anode seven-segment
//   display. A refresh divider selects one digit per slot; the first GUARD
//   cycles of every slot keep all anodes off to suppress ghosting. New values
//   are double-buffered and only committed at the frame boundary (last cycle
//   of digit 3), so one frame never mixes old and new data.
//
//   clock   system clock
//   nreset  asynchronous, active-low reset
//   bus     seven_seg_scanner_if.slave (data_in, load, blank_mask in;
//           busy, anode, segment out -- all outputs registered)
//
//   REFRESH_DIV  clock cycles per digit slot, 4..2^20
//   GUARD        blanked cycles at the start of each slot, 0..REFRESH_DIV-1
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000
) (
  input  logic               clock,
  input  logic               nreset,
  seven_seg_scanner_if.slave bus
);

  localparam int               DIV_W     = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_VAL = DIV_W'(GUARD);

  logic [DIV_W-1:0] div_reg;
  logic [1:0]       digit_reg;
  logic [15:0]      show_reg;
  logic [15:0]      pend_reg;
  logic             pend_flag_reg;
  logic [3:0]       anode_reg;
  logic [6:0]       segment_reg;

  logic       slot_end;
  logic       frame_end;
  logic       in_guard;
  logic       dark;
  logic [3:0] nibble;
  logic [6:0] seg_decoded;
  logic [3:0] anode_next;

  assign slot_end  = (div_reg == DIV_LAST);
  assign frame_end = slot_end && (digit_reg == 2'd3);

  // A zero-length guard would make the compare constant, so it is dropped
  // entirely in that case.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (div_reg < GUARD_VAL);
    end
  endgenerate

  assign dark   = in_guard || bus.blank_mask[digit_reg];
  assign nibble = show_reg[{digit_reg, 2'b00} +: 4];

  // One anode per digit: low only for the selected digit while lit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_anode
      assign anode_next[gi] = dark || (digit_reg != 2'(gi));
    end
  endgenerate

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    seg_decoded = 7'h7F;
    case (nibble)
      4'h0: seg_decoded = 7'h40;
      4'h1: seg_decoded = 7'h79;
      4'h2: seg_decoded = 7'h24;
      4'h3: seg_decoded = 7'h30;
      4'h4: seg_decoded = 7'h19;
      4'h5: seg_decoded = 7'h12;
      4'h6: seg_decoded = 7'h02;
      4'h7: seg_decoded = 7'h78;
      4'h8: seg_decoded = 7'h00;
      4'h9: seg_decoded = 7'h10;
      4'hA: seg_decoded = 7'h08;
      4'hB: seg_decoded = 7'h03;
      4'hC: seg_decoded = 7'h46;
      4'hD: seg_decoded = 7'h21;
      4'hE: seg_decoded = 7'h06;
      4'hF: seg_decoded = 7'h0E;
      default: seg_decoded = 7'h7F;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      div_reg       <= '0;
      digit_reg     <= 2'd0;
      show_reg      <= 16'h0000;
      pend_reg      <= 16'h0000;
      pend_flag_reg <= 1'b0;
      anode_reg     <= 4'b1111;
      segment_reg   <= 7'h7F;
    end else begin
      div_reg <= slot_end ? '0 : div_reg + 1'b1;
      if (slot_end) begin
        digit_reg <= digit_reg + 2'd1;
      end

      if (bus.load) begin
        pend_reg <= bus.data_in;
      end

      // A load landing exactly on the boundary bypasses the pending buffer,
      // so the flag never rises for it.
      if (frame_end) begin
        if (bus.load) begin
          show_reg <= bus.data_in;
        end else if (pend_flag_reg) begin
          show_reg <= pend_reg;
        end
        pend_flag_reg <= 1'b0;
      end else if (bus.load) begin
        pend_flag_reg <= 1'b1;
      end

      anode_reg   <= anode_next;
      segment_reg <= dark ? 7'h7F : seg_decoded;
    end
  end

  assign bus.busy    = pend_flag_reg;
  assign bus.anode   = anode_reg;
  assign bus.segment = segment_reg;

endmodule
